// File: rtl/act_feeder.sv
// act_feeder: activation-stream source for sblk_row.
// Decodes the tile instruction, derives the burst length n_tn*n_tp*N_TILE and
// streams that many packed activation pairs out of a 1-cycle-latency buffer,
// advancing a wrapping read pointer that carries over from burst to burst.
//
// Stream protocol: a burst is requested by a rising edge of the level signal
// act_data_in_req. The feeder answers with exactly len consecutive beats of
// act_data_out_vld (there is no backpressure), and burst_done is high together
// with the final beat. act_data_out is only meaningful while
// act_data_out_vld is high; it holds its last value otherwise.
module act_feeder #(
    parameter int N_TILE      = 4,
    parameter int WID_ACT     = 16,
    parameter int WID_BUFADDR = 8,
    parameter int WID_INST_TN = 3,
    parameter int WID_INST_TM = 3,
    parameter int WID_INST_TP = 2,
    parameter int WID_INST_LN = 3,
    parameter int WID_INST_LP = 3,
    parameter int WID_INST    = WID_INST_TN + WID_INST_TM + WID_INST_TP
                                + WID_INST_LN + WID_INST_LP
) (
    input  logic                   clk_l,
    input  logic                   rst,
    input  logic [WID_INST-1:0]    inst_data,
    input  logic                   inst_en,
    input  logic [WID_BUFADDR-1:0] base_addr,
    input  logic                   base_load,
    input  logic                   act_data_in_req,
    output logic                   mem_rd_en,
    output logic [WID_BUFADDR-1:0] mem_rd_addr,
    input  logic [2*WID_ACT-1:0]   mem_rd_data,
    output logic                   act_data_out_vld,
    output logic [2*WID_ACT-1:0]   act_data_out,
    output logic                   busy,
    output logic                   burst_done
);

    // Longest possible burst and the counter width that can hold it.
    localparam int MAX_LEN = ((1 << WID_INST_TN) - 1) * ((1 << WID_INST_TP) - 1) * N_TILE;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int TM_LSB  = WID_INST_TN;
    localparam int TP_LSB  = WID_INST_TN + WID_INST_TM;
    localparam int LN_LSB  = TP_LSB + WID_INST_TP;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t                   state;
    logic [WID_INST_TN-1:0]   cfg_tn;
    logic [WID_INST_TP-1:0]   cfg_tp;
    logic                     cfg_vld;
    logic [WID_INST_TN-1:0]   sh_tn;
    logic [WID_INST_TP-1:0]   sh_tp;
    logic                     sh_pend;
    logic [WID_BUFADDR-1:0]   pend_base;
    logic                     pend_base_vld;
    logic [WID_BUFADDR-1:0]   rd_ptr;
    logic [LEN_W-1:0]         rem;
    logic                     rd_en_r;
    logic                     rd_q;
    logic                     req_q;

    logic [WID_INST_TN-1:0]   inst_tn;
    logic [WID_INST_TM-1:0]   inst_tm;
    logic [WID_INST_TP-1:0]   inst_tp;
    logic [LEN_W-1:0]         cfg_len;
    int                       cfg_len_full;
    logic                     start;
    logic                     unused_inst_bits;

    // Instruction field decode; tm, ln and lp are carried but not needed here.
    assign inst_tn          = inst_data[WID_INST_TN-1:0];
    assign inst_tm          = inst_data[TM_LSB +: WID_INST_TM];
    assign inst_tp          = inst_data[TP_LSB +: WID_INST_TP];
    assign unused_inst_bits = ^{inst_tm, inst_data[WID_INST-1:LN_LSB]};

    // Burst length from the active configuration.
    assign cfg_len_full = int'(cfg_tn) * int'(cfg_tp) * N_TILE;
    assign cfg_len      = LEN_W'(cfg_len_full);

    // Rising edge of the request, only honoured while idle and configured.
    assign start = (state == S_IDLE) && cfg_vld && act_data_in_req && !req_q;

    assign mem_rd_en   = rd_en_r;
    assign mem_rd_addr = rd_ptr;

    // Request edge register and the two-stage read-return pipeline.
    always_ff @(posedge clk_l or posedge rst) begin
        if (rst) begin
            req_q            <= 1'b0;
            rd_q             <= 1'b0;
            act_data_out_vld <= 1'b0;
            act_data_out     <= '0;
        end else begin
            req_q            <= act_data_in_req;
            rd_q             <= rd_en_r;
            act_data_out_vld <= rd_q;
            if (rd_q) begin
                act_data_out <= mem_rd_data;
            end
        end
    end

    // Burst FSM with config/pointer bookkeeping and registered control outputs.
    always_ff @(posedge clk_l or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            cfg_tn        <= '0;
            cfg_tp        <= '0;
            cfg_vld       <= 1'b0;
            sh_tn         <= '0;
            sh_tp         <= '0;
            sh_pend       <= 1'b0;
            pend_base     <= '0;
            pend_base_vld <= 1'b0;
            rd_ptr        <= '0;
            rem           <= '0;
            rd_en_r       <= 1'b0;
            busy          <= 1'b0;
            burst_done    <= 1'b0;
        end else begin
            burst_done <= 1'b0;

            // While a burst runs, new config and base are parked until idle.
            if (state != S_IDLE) begin
                if (inst_en) begin
                    sh_tn   <= inst_tn;
                    sh_tp   <= inst_tp;
                    sh_pend <= 1'b1;
                end
                if (base_load) begin
                    pend_base     <= base_addr;
                    pend_base_vld <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (inst_en) begin
                        cfg_tn  <= inst_tn;
                        cfg_tp  <= inst_tp;
                        cfg_vld <= 1'b1;
                    end
                    // A base loaded on the start edge is the one the burst uses.
                    if (base_load) begin
                        rd_ptr <= base_addr;
                    end
                    if (start) begin
                        if (cfg_len == '0) begin
                            // Empty job: acknowledge without touching the buffer.
                            burst_done <= 1'b1;
                        end else begin
                            state   <= S_STREAM;
                            busy    <= 1'b1;
                            rd_en_r <= 1'b1;
                            rem     <= cfg_len;
                        end
                    end
                end

                S_STREAM: begin
                    rd_ptr <= rd_ptr + WID_BUFADDR'(1);
                    rem    <= rem - LEN_W'(1);
                    if (rem == LEN_W'(1)) begin
                        state   <= S_DRAIN;
                        rd_en_r <= 1'b0;
                    end
                end

                S_DRAIN: begin
                    if (!burst_done) begin
                        // Last read is one cycle from the output register.
                        burst_done <= 1'b1;
                    end else begin
                        // Final beat presented: release and apply parked updates.
                        state         <= S_IDLE;
                        busy          <= 1'b0;
                        sh_pend       <= 1'b0;
                        pend_base_vld <= 1'b0;
                        if (inst_en) begin
                            cfg_tn <= inst_tn;
                            cfg_tp <= inst_tp;
                        end else if (sh_pend) begin
                            cfg_tn <= sh_tn;
                            cfg_tp <= sh_tp;
                        end
                        if (base_load) begin
                            rd_ptr <= base_addr;
                        end else if (pend_base_vld) begin
                            rd_ptr <= pend_base;
                        end
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    rd_en_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_act_feeder.sv
// tb_act_feeder: directed bench for act_feeder with a 1-cycle-latency buffer model.
module tb_act_feeder;

    logic        clk_l = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] inst_data = '0;
    logic        inst_en = 1'b0;
    logic [7:0]  base_addr = '0;
    logic        base_load = 1'b0;
    logic        act_data_in_req = 1'b0;
    logic        mem_rd_en;
    logic [7:0]  mem_rd_addr;
    logic [31:0] mem_rd_data = '0;
    logic        act_data_out_vld;
    logic [31:0] act_data_out;
    logic        busy;
    logic        burst_done;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int busy_cnt = 0;

    logic [7:0]  rd_addr_q[$];
    logic [31:0] beat_q[$];
    int          vld_cyc_q[$];
    int          done_cyc_q[$];
    logic [31:0] exp_q[$];

    act_feeder dut (
        .clk_l(clk_l), .rst(rst), .inst_data(inst_data), .inst_en(inst_en),
        .base_addr(base_addr), .base_load(base_load), .act_data_in_req(act_data_in_req),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .act_data_out_vld(act_data_out_vld), .act_data_out(act_data_out),
        .busy(busy), .burst_done(burst_done)
    );

    // Clock and cycle counter.
    always #5 clk_l = ~clk_l;
    always @(posedge clk_l) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return {8'hA0 ^ a, a, 8'h3C + a, ~a};
    endfunction

    // Buffer model: data appears the cycle after the read enable.
    always @(posedge clk_l) if (mem_rd_en) mem_rd_data <= mem_word(mem_rd_addr);

    // Monitor, sampling away from the active edge.
    always @(negedge clk_l) begin
        if (mem_rd_en) rd_addr_q.push_back(mem_rd_addr);
        if (act_data_out_vld) begin
            beat_q.push_back(act_data_out);
            vld_cyc_q.push_back(cyc);
        end
        if (burst_done) done_cyc_q.push_back(cyc);
        if (busy) busy_cnt++;
    end

    function automatic logic [13:0] mk_inst(input logic [2:0] tn, input logic [1:0] tp);
        return {3'd5, 3'd2, tp, 3'd6, tn};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk_l);
    endtask

    task automatic clear_logs;
        #1;
        rd_addr_q.delete(); beat_q.delete(); vld_cyc_q.delete();
        done_cyc_q.delete(); exp_q.delete(); busy_cnt = 0;
    endtask

    task automatic drive_inst(input logic [2:0] tn, input logic [1:0] tp);
        @(negedge clk_l);
        inst_data = mk_inst(tn, tp);
        inst_en = 1'b1;
        @(negedge clk_l);
        inst_en = 1'b0;
    endtask

    task automatic drive_base(input logic [7:0] a);
        @(negedge clk_l);
        base_addr = a;
        base_load = 1'b1;
        @(negedge clk_l);
        base_load = 1'b0;
    endtask

    task automatic pulse_req(output int c0);
        @(negedge clk_l);
        act_data_in_req = 1'b1;
        c0 = cyc;
        @(negedge clk_l);
        act_data_in_req = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        idle(2);
        act_data_in_req = 1'b1;
        idle(1);
        #1;
        n_checks++; if (act_data_out_vld !== 1'b0) $display("FAIL rst_vld: got %b want 0", act_data_out_vld); else n_pass++;
        n_checks++; if (burst_done !== 1'b0) $display("FAIL rst_done: got %b want 0", burst_done); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (mem_rd_en !== 1'b0) $display("FAIL rst_rd_en: got %b want 0", mem_rd_en); else n_pass++;
        n_checks++; if (mem_rd_addr !== 8'h00) $display("FAIL rst_addr: got %h want 00", mem_rd_addr); else n_pass++;
        n_checks++; if (act_data_out !== 32'h0) $display("FAIL rst_data: got %h want 0", act_data_out); else n_pass++;
        act_data_in_req = 1'b0;
        @(negedge clk_l);
        rst = 1'b0;
        clear_logs();
        // Unconfigured: a request edge must be dropped.
        act_data_in_req = 1'b1;
        idle(1);
        act_data_in_req = 1'b0;
        idle(8);
        n_checks++; if (rd_addr_q.size() != 0) $display("FAIL nocfg_reads: got %0d want 0", rd_addr_q.size()); else n_pass++;
        n_checks++; if (done_cyc_q.size() != 0) $display("FAIL nocfg_done: got %0d want 0", done_cyc_q.size()); else n_pass++;
    endtask

    task automatic test_basic;
        int c0;
        clear_logs();
        drive_inst(3'd2, 2'd2);
        drive_base(8'h10);
        pulse_req(c0);
        idle(25);
        for (int i = 0; i < 16; i++) exp_q.push_back(mem_word(8'h10 + 8'(i)));
        n_checks++; if (rd_addr_q.size() != 16) $display("FAIL basic_nreads: got %0d want 16", rd_addr_q.size()); else n_pass++;
        n_checks++; if (beat_q.size() != 16) $display("FAIL basic_nbeats: got %0d want 16", beat_q.size()); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            n_checks++; if (rd_addr_q[i] !== 8'h10 + 8'(i)) $display("FAIL basic_addr[%0d]: got %h want %h", i, rd_addr_q[i], 8'h10 + 8'(i)); else n_pass++;
            n_checks++; if (beat_q[i] !== exp_q[i]) $display("FAIL basic_data[%0d]: got %h want %h", i, beat_q[i], exp_q[i]); else n_pass++;
            n_checks++; if (vld_cyc_q[i] != c0 + 3 + i) $display("FAIL basic_vld_cyc[%0d]: got %0d want %0d", i, vld_cyc_q[i], c0 + 3 + i); else n_pass++;
        end
        n_checks++; if (done_cyc_q.size() != 1) $display("FAIL basic_ndone: got %0d want 1", done_cyc_q.size()); else n_pass++;
        n_checks++; if (done_cyc_q[0] != c0 + 18) $display("FAIL basic_done_cyc: got %0d want %0d", done_cyc_q[0], c0 + 18); else n_pass++;
        n_checks++; if (busy_cnt != 18) $display("FAIL basic_busy_cycles: got %0d want 18", busy_cnt); else n_pass++;
        n_checks++; if (mem_rd_addr !== 8'h20) $display("FAIL basic_ptr_after: got %h want 20", mem_rd_addr); else n_pass++;
    endtask

    task automatic test_wrap;
        int c0;
        logic [7:0] a;
        clear_logs();
        drive_inst(3'd1, 2'd3);
        drive_base(8'hFA);
        pulse_req(c0);
        idle(20);
        n_checks++; if (beat_q.size() != 12) $display("FAIL wrap_nbeats: got %0d want 12", beat_q.size()); else n_pass++;
        for (int i = 0; i < 12; i++) begin
            a = (i < 6) ? 8'hFA + 8'(i) : 8'(i - 6);
            n_checks++; if (rd_addr_q[i] !== a) $display("FAIL wrap_addr[%0d]: got %h want %h", i, rd_addr_q[i], a); else n_pass++;
            n_checks++; if (beat_q[i] !== mem_word(a)) $display("FAIL wrap_data[%0d]: got %h want %h", i, beat_q[i], mem_word(a)); else n_pass++;
        end
        n_checks++; if (done_cyc_q[0] != c0 + 14) $display("FAIL wrap_done_cyc: got %0d want %0d", done_cyc_q[0], c0 + 14); else n_pass++;
    endtask

    task automatic test_zero_len;
        int c0;
        clear_logs();
        drive_inst(3'd0, 2'd2);
        pulse_req(c0);
        idle(10);
        n_checks++; if (rd_addr_q.size() != 0) $display("FAIL zero_reads: got %0d want 0", rd_addr_q.size()); else n_pass++;
        n_checks++; if (beat_q.size() != 0) $display("FAIL zero_beats: got %0d want 0", beat_q.size()); else n_pass++;
        n_checks++; if (done_cyc_q.size() != 1) $display("FAIL zero_ndone: got %0d want 1", done_cyc_q.size()); else n_pass++;
        n_checks++; if (done_cyc_q[0] != c0 + 1) $display("FAIL zero_done_cyc: got %0d want %0d", done_cyc_q[0], c0 + 1); else n_pass++;
        n_checks++; if (busy_cnt != 0) $display("FAIL zero_busy: got %0d want 0", busy_cnt); else n_pass++;
    endtask

    task automatic test_mid_inst;
        int c0;
        int c1;
        clear_logs();
        drive_inst(3'd2, 2'd2);
        pulse_req(c0);
        idle(3);
        drive_inst(3'd3, 2'd1);
        idle(25);
        pulse_req(c1);
        idle(20);
        n_checks++; if (beat_q.size() != 28) $display("FAIL mid_nbeats: got %0d want 28", beat_q.size()); else n_pass++;
        n_checks++; if (done_cyc_q.size() != 2) $display("FAIL mid_ndone: got %0d want 2", done_cyc_q.size()); else n_pass++;
        n_checks++; if (done_cyc_q[0] != c0 + 18) $display("FAIL mid_done0: got %0d want %0d", done_cyc_q[0], c0 + 18); else n_pass++;
        n_checks++; if (done_cyc_q[1] != c1 + 14) $display("FAIL mid_done1: got %0d want %0d", done_cyc_q[1], c1 + 14); else n_pass++;
        for (int i = 0; i < 28; i++) begin
            n_checks++; if (rd_addr_q[i] !== 8'h06 + 8'(i)) $display("FAIL mid_addr[%0d]: got %h want %h", i, rd_addr_q[i], 8'h06 + 8'(i)); else n_pass++;
        end
        n_checks++; if (vld_cyc_q[16] != c1 + 3) $display("FAIL mid_first_vld1: got %0d want %0d", vld_cyc_q[16], c1 + 3); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int c0;
        int c1;
        clear_logs();
        @(negedge clk_l);
        act_data_in_req = 1'b1;
        c0 = cyc;
        idle(40);
        act_data_in_req = 1'b0;
        idle(1);
        act_data_in_req = 1'b1;
        c1 = cyc;
        idle(4);
        act_data_in_req = 1'b0;
        idle(1);
        act_data_in_req = 1'b1;
        idle(30);
        act_data_in_req = 1'b0;
        idle(5);
        n_checks++; if (done_cyc_q.size() != 2) $display("FAIL b2b_ndone: got %0d want 2", done_cyc_q.size()); else n_pass++;
        n_checks++; if (beat_q.size() != 24) $display("FAIL b2b_nbeats: got %0d want 24", beat_q.size()); else n_pass++;
        n_checks++; if (done_cyc_q[0] != c0 + 14) $display("FAIL b2b_done0: got %0d want %0d", done_cyc_q[0], c0 + 14); else n_pass++;
        n_checks++; if (done_cyc_q[1] != c1 + 14) $display("FAIL b2b_done1: got %0d want %0d", done_cyc_q[1], c1 + 14); else n_pass++;
        for (int i = 0; i < 24; i++) begin
            n_checks++; if (beat_q[i] !== mem_word(8'h22 + 8'(i))) $display("FAIL b2b_data[%0d]: got %h want %h", i, beat_q[i], mem_word(8'h22 + 8'(i))); else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        int c0;
        int c2;
        clear_logs();
        drive_inst(3'd2, 2'd2);
        pulse_req(c0);
        for (int k = 0; k < 30 && beat_q.size() < 5; k++) begin
            @(negedge clk_l);
            #1;
        end
        n_checks++; if (beat_q.size() != 5) $display("FAIL rmid_reach_beat5: got %0d want 5", beat_q.size()); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (act_data_out_vld !== 1'b0) $display("FAIL rmid_vld: got %b want 0", act_data_out_vld); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (mem_rd_en !== 1'b0) $display("FAIL rmid_rd_en: got %b want 0", mem_rd_en); else n_pass++;
        n_checks++; if (act_data_out !== 32'h0) $display("FAIL rmid_data: got %h want 0", act_data_out); else n_pass++;
        @(negedge clk_l);
        rst = 1'b0;
        clear_logs();
        idle(25);
        n_checks++; if (beat_q.size() != 0) $display("FAIL rmid_stale_vld: got %0d want 0", beat_q.size()); else n_pass++;
        n_checks++; if (done_cyc_q.size() != 0) $display("FAIL rmid_stale_done: got %0d want 0", done_cyc_q.size()); else n_pass++;
        pulse_req(c2);
        idle(10);
        n_checks++; if (rd_addr_q.size() != 0) $display("FAIL rmid_req_nocfg: got %0d want 0", rd_addr_q.size()); else n_pass++;
        clear_logs();
        drive_inst(3'd1, 2'd1);
        pulse_req(c2);
        idle(12);
        n_checks++; if (beat_q.size() != 4) $display("FAIL rmid_nbeats: got %0d want 4", beat_q.size()); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (rd_addr_q[i] !== 8'(i)) $display("FAIL rmid_addr[%0d]: got %h want %h", i, rd_addr_q[i], 8'(i)); else n_pass++;
        end
        n_checks++; if (done_cyc_q[0] != c2 + 6) $display("FAIL rmid_done_cyc: got %0d want %0d", done_cyc_q[0], c2 + 6); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_zero_len();
        test_mid_inst();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
